ula_op_sequencer: RTL

//   Control FSM for one ALU operation: sequences the clock enables of the operand A,

---
 rtl/ula_op_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer
//   Control FSM for one ALU operation. It drives the clock enables of the
//   operand A, operand B, result and flag register banks. A request loads both
//   operands, then either runs a single-cycle op or launches an iterative
//   multi-cycle unit and waits on it, with a timeout. Finally it writes the
//   result and reports done (pulse) or err (sticky).
//
// Parameters
//   OPW      opcode width; op[OPW-1]=1 selects the multi-cycle path
//   TIMEOUT  maximum number of cycles spent waiting on the multi-cycle unit (>=2)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   request, sampled only while idle
//   op        in   opcode, captured with an accepted start
//   abort     in   synchronous cancel, highest priority in every state
//   mc_done   in   multi-cycle unit finished (level, only looked at while waiting)
//   en_a      out  load operand-A register
//   en_b      out  load operand-B register
//   en_res    out  load result register
//   en_flags  out  load flag register
//   mc_start  out  one-cycle launch pulse to the multi-cycle unit
//   alu_op    out  registered opcode driven to the datapath
//   busy      out  high in every state except idle
//   done      out  one-cycle completion pulse
//   err       out  sticky timeout flag, cleared by the next accepted start
module ula_op_sequencer #(
    parameter int OPW     = 3,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic           abort,
    input  logic           mc_done,
    output logic           en_a,
    output logic           en_b,
    output logic           en_res,
    output logic           en_flags,
    output logic           mc_start,
    output logic [OPW-1:0] alu_op,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT_MC = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            alu_op_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    alu_op_d = op;
                    err_d    = 1'b0;
                    state_d  = S_LOAD_A;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC: begin
                if (alu_op_q[OPW-1]) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_MC;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WAIT_MC: begin
                cnt_d = cnt_q + CW'(1);
                // mc_done wins over a timeout landing in the same cycle
                if (mc_done) begin
                    state_d = S_WRITE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Cancel discards every side effect of this cycle's transition,
        // so an aborted op can neither capture a new opcode nor raise err.
        if (abort) begin
            state_d  = S_IDLE;
            alu_op_d = alu_op_q;
            err_d    = err_q;
            cnt_d    = cnt_q;
        end
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    assign en_a     = (state_q == S_LOAD_A);
    assign en_b     = (state_q == S_LOAD_B);
    assign en_res   = (state_q == S_WRITE);
    assign en_flags = (state_q == S_WRITE);
    assign mc_start = (state_q == S_EXEC) && alu_op_q[OPW-1];
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign alu_op   = alu_op_q;
    assign err      = err_q;

endmodule
